// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller: req/ack data-memory handshake with upstream stall and MEM/WB result register.
// Optional build macro MEM_TIMEOUT_EN abandons a request after TIMEOUT_CYCLES unacknowledged REQ cycles.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_enable_in,
  input  logic               mem_rw_in,
  input  logic               mem_size_in,
  input  logic               mem_to_reg_select_in,
  input  logic               reg_write_enable_in,
  input  logic [3:0]         rd_in,
  input  logic [31:0]        addr_in,
  input  logic [31:0]        store_data_in,
  mem_access_stage_if.master dm,
  output logic               stall,
  output logic               wb_reg_write_enable_out,
  output logic [3:0]         wb_rd_out,
  output logic [31:0]        wb_data_out,
  output logic               align_fault_out,
  output logic               bus_fault_out
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        misaligned_p0;
  logic        start_p0;
  logic        timeout_hit;
  logic        timed_out;
  logic [1:0]  off_p1;
  logic        size_p1;
  logic [31:0] load_data_p1;

  function automatic logic [3:0] lane_enable(input logic byte_op, input logic [1:0] off);
    return byte_op ? (4'b0001 << off) : 4'hF;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic byte_op, input logic [31:0] d);
    return byte_op ? {4{d[7:0]}} : d;
  endfunction

  function automatic logic [31:0] load_extract(input logic byte_op, input logic [1:0] off,
                                               input logic [31:0] r);
    logic [7:0] b;
    case (off)
      2'd0:    b = r[7:0];
      2'd1:    b = r[15:8];
      2'd2:    b = r[23:16];
      default: b = r[31:24];
    endcase
    return byte_op ? {24'h0, b} : r;
  endfunction

  assign misaligned_p0 = mem_enable_in && !mem_size_in && (addr_in[1:0] != 2'b00);
  assign start_p0      = mem_enable_in && !misaligned_p0;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       timed_out_q;
  logic       unused_timeout;

  assign unused_timeout = 1'b0;
  assign timeout_hit    = (state_q == REQ) && !dm.dm_ack && (wait_cnt_q == TIMEOUT_LAST);
  assign timed_out      = timed_out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= 8'd0;
      timed_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (start_p0) wait_cnt_q <= 8'd0;
        REQ: begin
          if (timeout_hit)      timed_out_q <= 1'b1;
          else if (!dm.dm_ack)  wait_cnt_q  <= wait_cnt_q + 8'd1;
        end
        DONE:    timed_out_q <= 1'b0;
        default: ;
      endcase
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_LAST;
  assign timeout_hit    = 1'b0;
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (start_p0) begin
            stall   = 1'b1;
            state_d = REQ;
          end
        end
        REQ: begin
          stall = 1'b1;
          if (dm.dm_ack || timeout_hit) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // p0 -> p1: request launch, response capture and MEM/WB result register
  always_ff @(posedge clk) begin
    if (reset) begin
      dm.dm_req               <= 1'b0;
      dm.dm_we                <= 1'b0;
      dm.dm_addr              <= 32'h0;
      dm.dm_wdata             <= 32'h0;
      dm.dm_be                <= 4'h0;
      wb_reg_write_enable_out <= 1'b0;
      wb_rd_out               <= 4'h0;
      wb_data_out             <= 32'h0;
      align_fault_out         <= 1'b0;
      bus_fault_out           <= 1'b0;
    end else begin
      align_fault_out <= 1'b0;
      bus_fault_out   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!mem_enable_in) begin
            wb_reg_write_enable_out <= reg_write_enable_in;
            wb_rd_out               <= rd_in;
            wb_data_out             <= addr_in;
          end else if (misaligned_p0) begin
            align_fault_out         <= 1'b1;
            wb_reg_write_enable_out <= 1'b0;
          end else begin
            dm.dm_req               <= 1'b1;
            dm.dm_we                <= mem_rw_in;
            dm.dm_addr              <= {addr_in[31:2], 2'b00};
            dm.dm_wdata             <= lane_replicate(mem_size_in, store_data_in);
            dm.dm_be                <= lane_enable(mem_size_in, addr_in[1:0]);
            wb_reg_write_enable_out <= 1'b0;
          end
        end
        REQ: begin
          if (dm.dm_ack || timeout_hit) dm.dm_req <= 1'b0;
        end
        DONE: begin
          if (timed_out) begin
            bus_fault_out           <= 1'b1;
            wb_reg_write_enable_out <= 1'b0;
          end else begin
            wb_reg_write_enable_out <= reg_write_enable_in;
            wb_rd_out               <= rd_in;
            wb_data_out             <= mem_to_reg_select_in ? load_data_p1 : addr_in;
          end
        end
        default: ;
      endcase
    end
  end

  // Lane selection and captured load data carry no reset; they are qualified by the FSM.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start_p0) begin
      off_p1  <= addr_in[1:0];
      size_p1 <= mem_size_in;
    end
    if (state_q == REQ && dm.dm_ack) load_data_p1 <= load_extract(size_p1, off_p1, dm.dm_rdata);
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage against a transaction-level reference model.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_enable_in, mem_rw_in, mem_size_in, mem_to_reg_select_in, reg_write_enable_in;
  logic [3:0]  rd_in;
  logic [31:0] addr_in, store_data_in;
  logic        stall;
  logic        wb_reg_write_enable_out;
  logic [3:0]  wb_rd_out;
  logic [31:0] wb_data_out;
  logic        align_fault_out, bus_fault_out;

  mem_access_stage_if dmi ();

  mem_access_stage dut (
    .clk                     (clk),
    .reset                   (reset),
    .mem_enable_in           (mem_enable_in),
    .mem_rw_in               (mem_rw_in),
    .mem_size_in             (mem_size_in),
    .mem_to_reg_select_in    (mem_to_reg_select_in),
    .reg_write_enable_in     (reg_write_enable_in),
    .rd_in                   (rd_in),
    .addr_in                 (addr_in),
    .store_data_in           (store_data_in),
    .dm                      (dmi.master),
    .stall                   (stall),
    .wb_reg_write_enable_out (wb_reg_write_enable_out),
    .wb_rd_out               (wb_rd_out),
    .wb_data_out             (wb_data_out),
    .align_fault_out         (align_fault_out),
    .bus_fault_out           (bus_fault_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: memory-side view of one access, straight from the byte-lane rules.
  function automatic logic [3:0] exp_be(input logic byte_op, input logic [1:0] off);
    return byte_op ? 4'(1 << off) : 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic byte_op, input logic [31:0] d);
    return byte_op ? (d & 32'hFF) * 32'h0101_0101 : d;
  endfunction

  function automatic logic [31:0] exp_load(input logic byte_op, input logic [1:0] off,
                                           input logic [31:0] r);
    return byte_op ? (r >> (8 * off)) & 32'hFF : r;
  endfunction

  task automatic set_op(input logic me, input logic rw, input logic sz, input logic mts,
                        input logic rwe, input logic [3:0] rd, input logic [31:0] addr,
                        input logic [31:0] sd);
    mem_enable_in        = me;
    mem_rw_in            = rw;
    mem_size_in          = sz;
    mem_to_reg_select_in = mts;
    reg_write_enable_in  = rwe;
    rd_in                = rd;
    addr_in              = addr;
    store_data_in        = sd;
  endtask

  // Each op task starts at a negedge with inputs just driven and ends at the negedge after WB.
  task automatic run_nonmem();
    #1 chk("nonmem_stall", stall, 1'b0);
    @(negedge clk);
    chk("nonmem_wb_we",   wb_reg_write_enable_out, reg_write_enable_in);
    chk("nonmem_wb_rd",   wb_rd_out, rd_in);
    chk("nonmem_wb_data", wb_data_out, addr_in);
    chk("nonmem_align",   align_fault_out, 1'b0);
    chk("nonmem_req",     dmi.dm_req, 1'b0);
  endtask

  task automatic run_misaligned();
    #1 chk("mis_stall", stall, 1'b0);
    @(negedge clk);
    chk("mis_align", align_fault_out, 1'b1);
    chk("mis_wb_we", wb_reg_write_enable_out, 1'b0);
    chk("mis_req",   dmi.dm_req, 1'b0);
    chk("mis_stall_after", stall, 1'b0);
  endtask

  task automatic run_mem(input int delay, input logic [31:0] rdata);
    #1 chk("mem_stall_entry", stall, 1'b1);
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk);
      chk("req_dm_req",   dmi.dm_req, 1'b1);
      chk("req_dm_we",    dmi.dm_we, mem_rw_in);
      chk("req_dm_addr",  dmi.dm_addr, addr_in & 32'hFFFF_FFFC);
      chk("req_dm_be",    dmi.dm_be, exp_be(mem_size_in, addr_in[1:0]));
      chk("req_dm_wdata", dmi.dm_wdata, exp_wdata(mem_size_in, store_data_in));
      chk("req_stall",    stall, 1'b1);
      chk("req_wb_we",    wb_reg_write_enable_out, 1'b0);
      dmi.dm_ack   = (k == delay);
      dmi.dm_rdata = (k == delay) ? rdata : $urandom;
    end
    @(negedge clk);
    chk("done_dm_req", dmi.dm_req, 1'b0);
    chk("done_stall",  stall, 1'b0);
    dmi.dm_ack   = 1'($urandom_range(0, 1));
    dmi.dm_rdata = $urandom;
    @(negedge clk);
    dmi.dm_ack = 1'b0;
    chk("wb_we",   wb_reg_write_enable_out, reg_write_enable_in);
    chk("wb_rd",   wb_rd_out, rd_in);
    chk("wb_data", wb_data_out,
        mem_to_reg_select_in ? exp_load(mem_size_in, addr_in[1:0], rdata) : addr_in);
    chk("wb_bus_fault", bus_fault_out, 1'b0);
    chk("wb_align",     align_fault_out, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] sd;
    int          kind;

    reset        = 1'b1;
    dmi.dm_ack   = 1'b1;
    dmi.dm_rdata = 32'h0;
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h0000_0100, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall",    stall, 1'b0);
    chk("rst_dm_req",   dmi.dm_req, 1'b0);
    chk("rst_dm_we",    dmi.dm_we, 1'b0);
    chk("rst_dm_addr",  dmi.dm_addr, 32'h0);
    chk("rst_dm_wdata", dmi.dm_wdata, 32'h0);
    chk("rst_dm_be",    dmi.dm_be, 4'h0);
    chk("rst_wb_we",    wb_reg_write_enable_out, 1'b0);
    chk("rst_wb_rd",    wb_rd_out, 4'h0);
    chk("rst_wb_data",  wb_data_out, 32'h0);
    chk("rst_align",    align_fault_out, 1'b0);
    chk("rst_bus",      bus_fault_out, 1'b0);
    @(negedge clk);
    reset      = 1'b0;
    dmi.dm_ack = 1'b0;

    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h0000_1234, 32'h0);
    run_nonmem();
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 32'h0000_0100, 32'h0);
    run_mem(0, 32'hDEAD_BEEF);
    set_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0000_0203, 32'h0000_00A5);
    run_mem(4, 32'h0);
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 32'h0000_0202, 32'h0);
    run_mem(1, 32'h11CC_2233);
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 32'h0000_0102, 32'h0);
    run_misaligned();

    // Reset during REQ with a coincident ack, then the same op must restart from IDLE.
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 32'h0000_0300, 32'h0);
    #1 chk("rreq_stall", stall, 1'b1);
    @(negedge clk);
    reset        = 1'b1;
    dmi.dm_ack   = 1'b1;
    dmi.dm_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rreq_dm_req",  dmi.dm_req, 1'b0);
    chk("rreq_stall_r", stall, 1'b0);
    chk("rreq_wb_we",   wb_reg_write_enable_out, 1'b0);
    chk("rreq_wb_rd",   wb_rd_out, 4'h0);
    chk("rreq_wb_data", wb_data_out, 32'h0);
    reset      = 1'b0;
    dmi.dm_ack = 1'b0;
    run_mem(2, 32'h0BAD_F00D);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 4));
      a    = $urandom;
      sd   = $urandom;
      if (kind == 1 && a[1:0] == 2'b00) a[1:0] = 2'b01;
      if (kind == 2) a[1:0] = 2'b00;
      set_op(kind != 0, 1'($urandom_range(0, 1)), kind >= 3, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, sd);
      if (kind == 0)      run_nonmem();
      else if (kind == 1) run_misaligned();
      else                run_mem(int'($urandom_range(0, 6)), $urandom);
    end

`ifdef MEM_TIMEOUT_EN
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 32'h0000_0400, 32'h0);
    #1 chk("to_stall", stall, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("to_req", dmi.dm_req, 1'b1);
    end
    @(negedge clk);
    chk("to_done_req", dmi.dm_req, 1'b0);
    chk("to_done_bus", bus_fault_out, 1'b0);
    @(negedge clk);
    chk("to_bus_fault", bus_fault_out, 1'b1);
    chk("to_wb_we",     wb_reg_write_enable_out, 1'b0);
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h0000_0044, 32'h0);
    run_nonmem();
    chk("to_bus_clear", bus_fault_out, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller directly downstream of the ID/EX → EX/MEM control path.
- Consumes the memory control bits carried down the pipe (mem_enable, mem_rw, mem_size, mem_to_reg, reg_write) together with the EX results.
- Runs a req/ack handshake to data memory, stalling the pipeline while an access is outstanding.
- Registers the MEM/WB result: load data or ALU result, destination register, write enable.

Parameters:
TIMEOUT_CYCLES, 16, REQ cycles without dm_ack before an access is abandoned (used only with MEM_TIMEOUT_EN).

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
mem_enable_in  in  1  memory access this cycle
mem_rw_in  in  1  1 = store, 0 = load
mem_size_in  in  1  1 = byte, 0 = word
mem_to_reg_select_in  in  1  1 = writeback load data, 0 = ALU result
reg_write_enable_in  in  1  register write for this instruction
rd_in  in  4  destination register
addr_in  in  32  effective address (ALU result)
store_data_in  in  32  store source data
dm_req  out  1  memory request, registered
dm_we  out  1  write strobe, valid with dm_req
dm_addr  out  32  word-aligned address {addr[31:2],2'b00}
dm_wdata  out  32  store data
dm_be  out  4  byte enables
dm_ack  in  1  access complete; dm_rdata valid this cycle for loads
dm_rdata  in  32  load data
stall  out  1  combinational; holds all upstream pipeline registers
wb_reg_write_enable_out  out  1  MEM/WB write enable
wb_rd_out  out  4  MEM/WB destination
wb_data_out  out  32  MEM/WB writeback data
align_fault_out  out  1  one-cycle pulse: misaligned word access
bus_fault_out  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset: state IDLE; every registered output 0, including dm_req, dm_we, dm_addr, dm_wdata, dm_be and all wb_* / fault outputs; stall=0 while reset is high.
- States: IDLE, REQ, DONE.
- IDLE, mem_enable_in=0: stall=0. Next edge: wb_* ← {reg_write_enable_in, rd_in, addr_in}. Latency 1.
- IDLE, mem_enable_in=1, word with addr_in[1:0]≠0:
  - No request; stall=0.
  - Next edge: align_fault_out=1, wb_reg_write_enable_out=0.
- IDLE, mem_enable_in=1, otherwise:
  - stall=1 combinationally.
  - Next edge: latch dm_* from inputs, dm_req=1, state→REQ.
  - Same edge: wb_reg_write_enable_out←0 (bubble).
- Byte lanes:
  - word: dm_be=4'hF, dm_wdata=store_data_in.
  - byte: dm_be=1<<addr[1:0], dm_wdata=store_data_in[7:0] replicated ×4.
- REQ:
  - stall=1; dm_* held stable.
  - On dm_ack=1: capture load data, dm_req←0, state→DONE.
  - Load data: word → dm_rdata; byte → lane addr[1:0] of dm_rdata, zero-extended.
- DONE:
  - stall=0, so upstream advances this edge.
  - Next edge: wb_reg_write_enable_out←reg_write_enable_in, wb_rd_out←rd_in.
  - Same edge: wb_data_out←(mem_to_reg_select_in ? captured load data : addr_in); state→IDLE.
- Minimum memory-op occupancy is 3 cycles (IDLE→REQ→DONE) with ack on the first REQ cycle.
- Back-to-back memory ops: the second op is evaluated in the IDLE cycle after DONE.
- dm_ack is ignored in IDLE and DONE.
- Reset in REQ or DONE: next edge forces IDLE and dm_req=0; a coincident dm_ack is ignored; no WB write issued.
- No stall-in port; downstream WB never back-pressures.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - 8-bit counter clears on REQ entry and increments each REQ cycle without dm_ack.
  - When the count reaches TIMEOUT_CYCLES: dm_req←0, state→DONE, bus_fault_out pulses 1 in the cycle WB would update, and that WB is a bubble (wb_reg_write_enable_out=0).
- Undefined: REQ waits indefinitely; bus_fault_out tied 0.

Test Plan:
- Non-memory op: rd=3, addr=0x1234, reg_write=1 → next cycle wb_rd_out=3, wb_data_out=0x1234, wb_reg_write_enable_out=1, stall=0 throughout.
- Word load at 0x100, dm_ack on first REQ cycle with dm_rdata=0xDEADBEEF → stall high 2 cycles; dm_be=F, dm_addr=0x100; wb_data_out=0xDEADBEEF 3 cycles after entry.
- Byte store 0xA5 at 0x203 → dm_be=4'b1000, dm_wdata=0xA5A5A5A5, dm_we=1, wb_reg_write_enable_out=0; ack delayed 4 cycles → dm_* stable throughout.
- Byte load at 0x202, dm_rdata=0x11CC2233 → wb_data_out=0x000000CC.
- Word load at 0x102 → align_fault_out pulse, no dm_req, stall=0, WB bubble.
- Reset asserted mid-REQ with dm_ack coincident → next cycle dm_req=0, state IDLE, wb_* zero. With MEM_TIMEOUT_EN and no ack → bus_fault_out after 16 REQ cycles.
